// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    // Baud tick rate relative to the bit rate.
    localparam int unsigned OVERSAMPLE = 16;
    // Tick index that lands in the middle of the start bit.
    localparam int unsigned MID_START  = 7;

    // Tick counter width: wide enough for the stop-bit span, never below one bit period.
    function automatic int unsigned tick_cnt_width(input int unsigned sb_tick);
        int unsigned w;
        w = $clog2(sb_tick);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs.
//   clk   : destination clock
//   reset : asynchronous, active-low; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, 2 clk of latency
module sync_2ff #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (16x baud tick, LSB first, no parity).
//   clk          : system clock
//   reset        : asynchronous, active-low
//   rx           : raw serial input, idle high, asynchronous to clk
//   s_tick       : one-clk pulse at 16x baud
//   rx_done_tick : one-clk pulse when a frame completes
//   dout         : last received byte, held until the next frame
//   frame_err    : qualified by rx_done_tick; 1 = stop bit sampled low
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
);

    localparam int unsigned SW = tick_cnt_width(SB_TICK);
    localparam int unsigned NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID  = SW'(MID_START);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_s;
    uart_rx_state_t  state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_d;
    logic            done_d, ferr_d;
    // armed: line has been seen high since the last start, so a low level is a real falling edge
    logic            armed_q, armed_d;
    // settle: counts out the sync flops' reset value before rx_s is trusted to arm
    logic [1:0]      settle_q, settle_d;

    // Pad synchroniser, idles high like the line.
    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            armed_q      <= 1'b0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            dout         <= dout_d;
            rx_done_tick <= done_d;
            frame_err    <= ferr_d;
            armed_q      <= armed_d;
            settle_q     <= settle_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        dout_d   = dout;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
        armed_d  = armed_q;
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

        if (rx_s && (settle_q == 2'd3)) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Start detect runs on every clk, not just on ticks.
                if (!rx_s && armed_q) begin
                    state_d = START;
                    s_d     = '0;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                        // A low stop bit (break) must see the line return high before re-arming.
                        if (!rx_s) begin
                            armed_d = 1'b0;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver: recovers serial bytes from the external rx pin and feeds the rx FIFO inside the uart core.
- The uart MMIO slot reads that FIFO, together with the rx_empty status.
- Shares the baud tick (16x oversampling, divisor set through the slot's dvsr register) with the transmitter.
- Emits one data-valid pulse per received frame, plus a framing-error flag.

Parameters:
- DBIT, 8: data bits per frame, LSB first; legal range 5..9.
- SB_TICK, 16: oversampling ticks for the stop bit; 16/24/32 = 1/1.5/2 stop bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx  in  1  raw serial input from pad; idle high; asynchronous to clk
- s_tick  in  1  one-clk pulse at 16x baud, from the baud generator
- rx_done_tick  out  1  one-clk pulse: frame complete, dout and frame_err valid
- dout  out  DBIT  last received byte, held until the next frame completes
- frame_err  out  1  valid only while rx_done_tick=1; 1 means the stop bit was sampled low

Behaviour:
- Reset: reset low clears all state immediately.
  - Sync flops are set to 1 (idle line); state=IDLE; s=0; n=0; b=0.
  - dout=0, rx_done_tick=0, frame_err=0.
  - Releasing reset mid-line with rx low must not produce a frame until a fresh 1->0 transition after the sync flops read 1.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s, adding 2 clk of latency.
- Counters:
  - s: tick counter, width $clog2(SB_TICK), minimum 4.
  - n: bit counter, width $clog2(DBIT).
  - b: DBIT-bit shift register.
- s_tick is the only enable. With s_tick=0, state and counters hold, except the IDLE start detect, which acts on any clk.
- IDLE: when rx_s=0 (start edge), go to START with s=0.
- START, on each s_tick:
  - If s==7 (mid start bit) and rx_s=0: go to DATA with s=0, n=0.
  - If s==7 and rx_s=1: glitch; return to IDLE with no output activity.
  - Otherwise s++.
- DATA, on each s_tick:
  - If s==15: sample mid-bit, s=0, b={rx_s, b[DBIT-1:1]}. If n==DBIT-1 go to STOP, else n++.
  - Otherwise s++.
- STOP, on each s_tick:
  - If s==SB_TICK-1: pulse rx_done_tick for exactly 1 clk, load dout<=b, set frame_err<=~rx_s (registered, same cycle as the pulse), go to IDLE.
  - Otherwise s++.
- Outputs: all registered; rx_done_tick and frame_err are 0 in every other cycle.
- Framing error: a byte with frame_err=1 is still delivered. The core pushes it into the FIFO; dropping it is the core's decision.
- Break condition (rx held low): frame completes with frame_err=1. The block then re-enters START only after rx_s returns to 1 and falls again; IDLE requires a high-to-low transition, tracked by one flag register.
- Back-to-back frames: a new start bit arriving in the same tick that STOP exits must still be detected. IDLE reacts on the next clk.
- Latency: start-edge sample to rx_done_tick = 2 clk + (8 + 16*DBIT + SB_TICK) ticks, ±1 clk.
- No parity support; excluded by decision.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t (shared with uart_tx)
  - localparam OVERSAMPLE=16
  - localparam MID_START=7
- One sub-module: sync_2ff (parameterised reset value, here 1), reused by other pad inputs.

Test Plan:
- s_tick every 4 clk. Serialise 0x55 with 1 start, 8 data, 1 stop bit -> exactly one rx_done_tick, dout=0x55, frame_err=0. No pulse before the stop-bit tick 15.
- Back-to-back 0xA3 then 0x0F with zero idle between stop and next start -> two pulses, dout=0xA3 then 0x0F, frame_err=0 both.
- Low glitch of 5 ticks, then high -> no rx_done_tick, state back to IDLE. A following 0x3C frame is received correctly.
- Frame 0x81 with stop bit driven 0, then line high -> one pulse with frame_err=1 and dout=0x81; the next valid 0x7E gives frame_err=0.
- Assert reset low during bit 4 of a frame, release with line high, then send 0xC9 -> outputs 0 during reset, no spurious pulse, then dout=0xC9.
- SB_TICK=32: send 0x12 -> the pulse arrives 16 ticks later than with SB_TICK=16, dout=0x12.
